// File: rtl/pe_neuron_core_pkg.sv
// Shared PE definitions: packet field encodings, neuron FSM states, packet width helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pe_neuron_core_pkg;

  localparam int TYPE_W = 2;

  typedef enum logic [TYPE_W-1:0] {
    PKT_WEIGHT = 2'b00,
    PKT_DATA   = 2'b01,
    PKT_BIAS   = 2'b10,
    PKT_RSVD   = 2'b11
  } pkt_type_t;

  typedef enum logic [1:0] {
    ST_ACCUM    = 2'd0,
    ST_FIRE     = 2'd1,
    ST_OUT_WAIT = 2'd2
  } pe_state_t;

  // Packet is {TYPE, SEQ, SRC, PAYLOAD}, MSB first.
  function automatic int pkt_w(input int seq_w, input int src_w, input int data_w);
    return TYPE_W + seq_w + src_w + data_w;
  endfunction

endpackage

// File: rtl/pe_fifo.sv
// Generic show-ahead FIFO with full/empty flags; DEPTH must be a power of 2 (>= 2).
// Latency: a pushed word is visible on dout the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; caller gates on the flags.
module pe_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset empties the queue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/pe_neuron_core.sv
// Neuron PE: buffers inbound packets, accumulates data*weight per sequence, emits a clamped activation.
// Latency: result valid 2 edges after the edge that accepts the final data packet (FIFO empty).
// Backpressure: NI_PE_ready = !fifo_full; no pops while an output waits on PE_NI_ready.
module pe_neuron_core
  import pe_neuron_core_pkg::*;
#(
  parameter int SOURCE_ADDRESS = 1,
  parameter int NUM_INPUTS     = 4,
  parameter int DATA_W         = 8,
  parameter int SEQ_W          = 8,
  parameter int SRC_W          = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int AF_MODE        = 0
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       NI_PE_valid,
  input  logic [pkt_w(SEQ_W, SRC_W, DATA_W)-1:0]     NI_PE_packet,
  output logic                                       NI_PE_ready,
  output logic                                       PE_NI_valid,
  output logic [pkt_w(SEQ_W, SRC_W, DATA_W)-1:0]     PE_NI_packet,
  input  logic                                       PE_NI_ready,
  output logic [7:0]                                 drop_count
);

  localparam int PKT_W  = pkt_w(SEQ_W, SRC_W, DATA_W);
  localparam int IDX_W  = $clog2(NUM_INPUTS);
  localparam int CNT_W  = $clog2(NUM_INPUTS + 1);
  localparam int PROD_W = 2 * DATA_W;
  localparam int ACC_W  = 2 * DATA_W + $clog2(NUM_INPUTS) + 1;

  // Clamp bounds, sign-extended to the accumulator width for comparison.
  localparam logic signed [ACC_W-1:0]  ACC_HI = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0]  ACC_LO = (AF_MODE == 0) ? '0 :
                                                {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] RES_HI = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] RES_LO = (AF_MODE == 0) ? '0 : {1'b1, {(DATA_W-1){1'b0}}};

  pe_state_t state, state_nxt;

  logic                     fifo_full, fifo_empty, fifo_pop;
  logic [PKT_W-1:0]         head;
  logic [TYPE_W-1:0]        h_type;
  logic [SEQ_W-1:0]         h_seq;
  logic [SRC_W-1:0]         h_src;
  logic signed [DATA_W-1:0] h_pay;
  logic [IDX_W-1:0]         src_idx;
  logic                     src_ok, data_ok, weight_ok, bias_ld, drop;
  logic                     fire, out_ack;

  logic signed [DATA_W-1:0] weight [NUM_INPUTS];
  logic signed [DATA_W-1:0] bias;
  logic signed [ACC_W-1:0]  acc;
  logic signed [PROD_W-1:0] prod;
  logic signed [DATA_W-1:0] result;
  logic [SEQ_W-1:0]         cur_seq;
  logic [CNT_W-1:0]         count;
  logic [NUM_INPUTS-1:0]    seen;

  pe_fifo #(.WIDTH(PKT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (NI_PE_valid && NI_PE_ready),
    .din   (NI_PE_packet),
    .pop   (fifo_pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign NI_PE_ready = !fifo_full;

  // Head-of-queue decode and per-type acceptance.
  assign {h_type, h_seq, h_src, h_pay} = head;
  assign src_idx   = h_src[IDX_W-1:0];
  assign src_ok    = int'(h_src) < NUM_INPUTS;
  assign data_ok   = fifo_pop && (h_type == PKT_DATA) && (h_seq == cur_seq) && src_ok && !seen[src_idx];
  assign weight_ok = fifo_pop && (h_type == PKT_WEIGHT) && src_ok;
  assign bias_ld   = fifo_pop && (h_type == PKT_BIAS);
  assign drop      = fifo_pop && !(data_ok || weight_ok || bias_ld);
  assign prod      = PROD_W'(h_pay) * PROD_W'(weight[src_idx]);

  // Activation: saturate the accumulator into the payload range.
  always_comb begin
    result = acc[DATA_W-1:0];
    if (acc > ACC_HI)      result = RES_HI;
    else if (acc < ACC_LO) result = RES_LO;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_ACCUM;
    else      state <= state_nxt;
  end

  // FSM next state: fire once the last distinct input of the sequence lands.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_ACCUM:    if (data_ok && (count == CNT_W'(NUM_INPUTS - 1))) state_nxt = ST_FIRE;
      ST_FIRE:     state_nxt = ST_OUT_WAIT;
      ST_OUT_WAIT: if (PE_NI_ready) state_nxt = ST_ACCUM;
      default:     state_nxt = ST_ACCUM;
    endcase
  end

  // FSM outputs: pop only while accumulating, FIFO keeps filling otherwise.
  always_comb begin
    fifo_pop = (state == ST_ACCUM) && !fifo_empty;
    fire     = (state == ST_FIRE);
    out_ack  = (state == ST_OUT_WAIT) && PE_NI_ready;
  end

  // Weight table updates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_INPUTS; i++) weight[i] <= '0;
    end else if (weight_ok) begin
      weight[src_idx] <= h_pay;
    end
  end

  // Accumulation, output register, sequence advance and drop counting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc          <= '0;
      bias         <= '0;
      cur_seq      <= '0;
      count        <= '0;
      seen         <= '0;
      drop_count   <= '0;
      PE_NI_valid  <= 1'b0;
      PE_NI_packet <= '0;
    end else begin
      if (bias_ld) bias <= h_pay;
      if (data_ok) begin
        acc           <= acc + ACC_W'(prod);
        seen[src_idx] <= 1'b1;
        count         <= count + CNT_W'(1);
      end
      if (drop && (drop_count != 8'hFF)) drop_count <= drop_count + 8'd1;
      if (fire) begin
        PE_NI_packet <= {PKT_DATA, cur_seq, SRC_W'(SOURCE_ADDRESS), result};
        PE_NI_valid  <= 1'b1;
      end
      if (out_ack) begin
        PE_NI_valid <= 1'b0;
        cur_seq     <= cur_seq + SEQ_W'(1);
        acc         <= ACC_W'(bias);
        seen        <= '0;
        count       <= '0;
      end
    end
  end

endmodule

// File: doc/pe_neuron_core.md
PE_NEURON_CORE -- requirements
Module: pe_neuron_core

Interface
REQ-001 Parameter SOURCE_ADDRESS, default 1, SRC field stamped on every emitted packet.
REQ-002 Parameter NUM_INPUTS, default 4, number of data inputs summed per neuron firing (2..64).
REQ-003 Parameter DATA_W, default 8, signed width of data, weight and bias payloads.
REQ-004 Parameter SEQ_W, default 8; SRC_W, default 8; FIFO_DEPTH, default 4 (power of 2); AF_MODE, default 0 (0 = saturating ReLU, 1 = saturating identity).
REQ-005 Packet layout, MSB first: TYPE[1:0], SEQ[SEQ_W], SRC[SRC_W], PAYLOAD[DATA_W]; PKT_W = 2+SEQ_W+SRC_W+DATA_W.
REQ-006 clk  input  1  single clock, rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 NI_PE_valid  input  1; NI_PE_packet  input  PKT_W; NI_PE_ready  output  1: inbound valid/ready channel.
REQ-009 PE_NI_valid  output  1; PE_NI_packet  output  PKT_W; PE_NI_ready  input  1: outbound valid/ready channel.
REQ-010 drop_count  output  8  saturating count of discarded packets.

Function
REQ-011 Inbound transfer occurs on a rising edge with NI_PE_valid && NI_PE_ready; the packet is written to an input FIFO of FIFO_DEPTH entries.
REQ-012 NI_PE_ready = !fifo_full (combinational); a simultaneous push and pop on a full FIFO is not permitted (ready is low).
REQ-013 FSM states ACCUM, FIRE, OUT_WAIT; reset state ACCUM.
REQ-014 ACCUM: one FIFO entry popped and processed per cycle when non-empty.
REQ-015 TYPE 00 (weight): weight[SRC] <= PAYLOAD; takes effect for later data; SRC >= NUM_INPUTS -> drop.
REQ-016 TYPE 10 (bias): bias <= PAYLOAD; applied at start of next sequence.
REQ-017 TYPE 01 (data): accepted only if SEQ == cur_seq, SRC < NUM_INPUTS, and seen[SRC] clear; then acc <= acc + PAYLOAD*weight[SRC] (signed, full 2*DATA_W product), seen[SRC] set, count+1; otherwise dropped.
REQ-018 TYPE 11 -> dropped.
REQ-019 Every drop increments drop_count, saturating at 255.
REQ-020 Accumulator width ACC_W = 2*DATA_W + clog2(NUM_INPUTS) + 1, signed, never overflows.
REQ-021 When count reaches NUM_INPUTS, next state FIRE; no pops in FIRE or OUT_WAIT (FIFO continues filling).
REQ-022 FIRE (one cycle): result = AF_MODE 0 ? clamp(acc, 0, 2^(DATA_W-1)-1) : clamp(acc, -2^(DATA_W-1), 2^(DATA_W-1)-1); output register <= {2'b01, cur_seq, SOURCE_ADDRESS, result}; PE_NI_valid <= 1; go OUT_WAIT.
REQ-023 OUT_WAIT: PE_NI_valid and PE_NI_packet held stable until PE_NI_ready sampled high; on that edge valid <= 0, cur_seq <= cur_seq+1 (wraps mod 2^SEQ_W), acc <= sign-extended bias, seen <= 0, count <= 0, go ACCUM.
REQ-024 Latency: with empty FIFO, PE_NI_valid rises at the 2nd rising edge after the edge accepting the final data packet.
REQ-025 Sustained throughput: one FIFO entry per cycle in ACCUM.

Reset
REQ-026 On rst low, asynchronously: FSM ACCUM, FIFO empty, PE_NI_valid 0, PE_NI_packet 0, acc 0, bias 0, cur_seq 0, count 0, seen 0, drop_count 0, all weights 0.
REQ-027 Reset mid-sequence or during OUT_WAIT discards partial sums and pending output; no packet is emitted afterwards for that sequence.
REQ-028 NI_PE_ready is 1 during and immediately after reset (FIFO empty).

Structure
REQ-029 Packet field widths, TYPE encodings, and PKT_W function live in the shared header package used by all PE blocks.
REQ-030 Input FIFO is one sub-module, pe_fifo (parametrised width/depth, async active-low reset, full/empty flags).

Verification
REQ-031 Weights 1,2,3,4 to SRC 0..3, data 1,1,1,1 SEQ 0 -> one packet {01, 0, SOURCE_ADDRESS, 10}.
REQ-032 AF_MODE 0, weight -2 everywhere, data 5 x4 -> payload 0; weights 127, data 127 x4 -> payload 127; AF_MODE 1 weights -128, data 127 -> payload -128.
REQ-033 PE_NI_ready held 0 after firing, 6 back-to-back packets -> exactly 4 accepted, NI_PE_ready low, output packet stable; release ready -> queued packets drained in seq 1.
REQ-034 Data with SEQ 3 while cur_seq 0, duplicate SRC 1, SRC 9, TYPE 11 -> all dropped, drop_count = 4, no output.
REQ-035 Bias 5, then full sequence with sum 10 -> seq 1 payload 15; cur_seq wraps 255 -> 0 with SEQ_W 8.
REQ-036 rst asserted after 2 of 4 data packets -> outputs reset immediately; 4 new packets SEQ 0 -> single correct result.
